exc_ctrl: RTL and testbench

- Exception/interrupt controller and CP0 register file for the 5-stage MIPS pipeline.
- Samples the M-stage instruction (PC, exception code, branch-delay flag, MTC0/ERET) and the hardware interrupt lines.
- Drives IntReq, EretFlush and EPCOut to every pipeline register.
- Issues a D-stage stall when an ERET would read a stale EPC.

---
 rtl/exc_ctrl_pkg.sv | 31 +++
 rtl/exc_ctrl_if.sv | 38 +++
 rtl/exc_ctrl_cp0_regfile.sv | 80 ++++++++
 rtl/exc_ctrl.sv | 71 +++++++
 tb/tb_exc_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl shared definitions
// CP0 register numbers, exception codes, vectors
package exc_ctrl_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;

  typedef struct packed {
    logic        bd;
    logic [4:0]  code;
    logic [31:0] epc;
  } exc_req_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl pipeline-facing bundle
// master = pipeline, slave = controller
interface exc_ctrl_if #(
  parameter int HW_IRQ_W = 6
);
  logic [HW_IRQ_W-1:0] HWInt;
  logic [31:0]         PCM;
  logic [4:0]          ECM;
  logic                BDM;
  logic                CP0WeM;
  logic [4:0]          CP0AddrM;
  logic [31:0]         CP0WDM;
  logic                EretM;
  logic                EretD;
  logic                MtEpcE;
  logic [31:0]         CP0RD;
  logic                IntReq;
  logic                EretFlush;
  logic [31:0]         EPCOut;
  logic                StallEret;

  modport master (
    output HWInt, PCM, ECM, BDM,
    output CP0WeM, CP0AddrM, CP0WDM,
    output EretM, EretD, MtEpcE,
    input  CP0RD, IntReq, EretFlush,
    input  EPCOut, StallEret
  );

  modport slave (
    input  HWInt, PCM, ECM, BDM,
    input  CP0WeM, CP0AddrM, CP0WDM,
    input  EretM, EretD, MtEpcE,
    output CP0RD, IntReq, EretFlush,
    output EPCOut, StallEret
  );

endinterface

// File: rtl/exc_ctrl_cp0_regfile.sv
// CP0 storage: SR / Cause / EPC
// write masking and MFC0 read mux
module cp0_regfile
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h2021_0B0A,
  parameter int          HW_IRQ_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HW_IRQ_W-1:0] hwint,
  input  logic                exc_we,
  input  exc_req_t            exc,
  input  logic                mtc0_we,
  input  logic [4:0]          addr,
  input  logic [31:0]         wdata,
  input  logic                eret,
  output logic [HW_IRQ_W-1:0] im,
  output logic                exl,
  output logic                ie,
  output logic [31:0]         epc,
  output logic [31:0]         rdata
);

  logic                bd;
  logic [HW_IRQ_W-1:0] ip;
  logic [4:0]          code;
  logic [31:0]         sr_w;
  logic [31:0]         cause_w;

  assign sr_w = {16'h0, im, 8'h0, exl, ie};
  assign cause_w = {bd, 15'h0, ip, 3'b0, code, 2'b0};

  // exception entry owns the update; MTC0/ERET only otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      im   <= '0;
      exl  <= 1'b0;
      ie   <= 1'b0;
      bd   <= 1'b0;
      ip   <= '0;
      code <= '0;
      epc  <= '0;
    end else begin
      ip <= hwint;
      if (exc_we) begin
        exl  <= 1'b1;
        bd   <= exc.bd;
        code <= exc.code;
        epc  <= exc.epc;
      end else begin
        if (mtc0_we) begin
          case (addr)
            CP0_SR: begin
              im  <= wdata[15:10];
              exl <= wdata[1];
              ie  <= wdata[0];
            end
            CP0_EPC: epc <= word_align(wdata);
            default: ;
          endcase
        end
        if (eret) exl <= 1'b0;
      end
    end
  end

  // MFC0 read shows pre-edge state
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (addr == CP0_SR):    rdata = sr_w;
      (addr == CP0_CAUSE): rdata = cause_w;
      (addr == CP0_EPC):   rdata = epc;
      (addr == CP0_PRID):  rdata = PRID;
      default:             rdata = '0;
    endcase
  end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt arbitration
// flush, ERET redirect and EPC hazard stall
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h2021_0B0A,
  parameter int          HW_IRQ_W = 6
) (
  input  logic      clk,
  input  logic      reset,
  exc_ctrl_if.slave bus
);

  logic [HW_IRQ_W-1:0] im;
  logic                exl;
  logic                ie;
  logic [31:0]         epc;
  logic                int_pend;
  logic                exc_pend;
  logic                int_req;
  logic                eret_flush;
  logic                mtc0_we;
  logic                epc_hazard;
  exc_req_t            req;

  // arbitration: interrupt beats exception, both beat MTC0/ERET
  always_comb begin
    int_pend   = (|(bus.HWInt & im)) & ie & ~exl;
    exc_pend   = (bus.ECM != EXC_INT) & ~exl;
    int_req    = int_pend | exc_pend;
    eret_flush = bus.EretM & ~int_req;
    mtc0_we    = bus.CP0WeM & ~int_req;
    req.bd     = bus.BDM;
    req.code   = int_pend ? EXC_INT : bus.ECM;
    req.epc    = word_align(bus.BDM ? bus.PCM - 32'd4
                                    : bus.PCM);
  end

  // stall D-stage ERET while an EPC write is still in flight
  always_comb begin
    epc_hazard = bus.MtEpcE |
                 (bus.CP0WeM & (bus.CP0AddrM == CP0_EPC));
    bus.StallEret = bus.EretD & epc_hazard &
                    ~int_req & ~eret_flush;
  end

  assign bus.IntReq    = int_req;
  assign bus.EretFlush = eret_flush;
  assign bus.EPCOut    = epc;

  cp0_regfile #(
    .PRID     (PRID),
    .HW_IRQ_W (HW_IRQ_W)
  ) u_cp0 (
    .clk     (clk),
    .reset   (reset),
    .hwint   (bus.HWInt),
    .exc_we  (int_req),
    .exc     (req),
    .mtc0_we (mtc0_we),
    .addr    (bus.CP0AddrM),
    .wdata   (bus.CP0WDM),
    .eret    (eret_flush),
    .im      (im),
    .exl     (exl),
    .ie      (ie),
    .epc     (epc),
    .rdata   (bus.CP0RD)
  );

endmodule

// File: tb/tb_exc_ctrl.sv
// exc_ctrl bench: directed vectors,
// queue scoreboard with negedge monitor
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  typedef struct {
    string       nm;
    logic        ir;
    logic        ef;
    logic [31:0] epc;
    logic        st;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];

  exc_ctrl_if #(.HW_IRQ_W(6)) bus ();

  exc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s got %h want %h",
                  nm, f, act, req);
  endtask

  // monitor: compare every expectation pushed this cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "IntReq", 32'(bus.IntReq), 32'(e.ir));
      chk(e.nm, "EretFlush", 32'(bus.EretFlush), 32'(e.ef));
      chk(e.nm, "EPCOut", bus.EPCOut, e.epc);
      chk(e.nm, "StallEret", 32'(bus.StallEret), 32'(e.st));
      chk(e.nm, "CP0RD", bus.CP0RD, e.rd);
    end
  end

  task automatic cyc(
    input string       nm,
    input logic        rst,
    input logic [5:0]  hw,
    input logic [31:0] pc,
    input logic [4:0]  ec,
    input logic        bd,
    input logic        we,
    input logic [4:0]  ad,
    input logic [31:0] wd,
    input logic        em,
    input logic        ed,
    input logic        me,
    input logic        x_ir,
    input logic        x_ef,
    input logic [31:0] x_epc,
    input logic        x_st,
    input logic [31:0] x_rd
  );
    exp_t e;
    reset        = rst;
    bus.HWInt    = hw;
    bus.PCM      = pc;
    bus.ECM      = ec;
    bus.BDM      = bd;
    bus.CP0WeM   = we;
    bus.CP0AddrM = ad;
    bus.CP0WDM   = wd;
    bus.EretM    = em;
    bus.EretD    = ed;
    bus.MtEpcE   = me;
    e.nm = nm;
    e.ir = x_ir;
    e.ef = x_ef;
    e.epc = x_epc;
    e.st = x_st;
    e.rd = x_rd;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.HWInt = '0;
    bus.PCM = 32'h3000;
    bus.ECM = '0;
    bus.BDM = 1'b0;
    bus.CP0WeM = 1'b0;
    bus.CP0AddrM = '0;
    bus.CP0WDM = '0;
    bus.EretM = 1'b0;
    bus.EretD = 1'b0;
    bus.MtEpcE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //  name    rst hw     pc        ec  bd we ad  wd    em ed me | ir ef epc st rd
    cyc("rst_sr", 0, 6'h00, 32'h3000, 0, 0, 0, 12, 0, 0, 0, 0,
        0, 0, 32'h0, 0, 32'h0);
    cyc("rst_ca", 0, 6'h00, 32'h3004, 0, 0, 0, 13, 0, 0, 0, 0,
        0, 0, 32'h0, 0, 32'h0);
    cyc("mt_sr", 0, 6'h00, 32'h3008, 0, 0, 1, 12, 32'h401, 0, 0, 0,
        0, 0, 32'h0, 0, 32'h0);
    cyc("irq", 0, 6'h01, 32'h3010, 0, 0, 0, 12, 0, 0, 0, 0,
        1, 0, 32'h0, 0, 32'h401);
    cyc("irq_ca", 0, 6'h01, 32'h3014, 0, 0, 0, 13, 0, 0, 0, 0,
        0, 0, 32'h3010, 0, 32'h400);
    cyc("mask_sr", 0, 6'h01, 32'h3018, EXC_ADEL, 0, 0, 12, 0, 0, 0, 0,
        0, 0, 32'h3010, 0, 32'h403);
    cyc("mask_ip", 0, 6'h20, 32'h301c, EXC_ADEL, 0, 0, 13, 0, 0, 0, 0,
        0, 0, 32'h3010, 0, 32'h400);
    cyc("ip_trk", 0, 6'h00, 32'h3020, 0, 0, 0, 13, 0, 0, 0, 0,
        0, 0, 32'h3010, 0, 32'h8000);
    cyc("eret", 0, 6'h00, 32'h3024, 0, 0, 0, 14, 0, 1, 0, 0,
        0, 1, 32'h3010, 0, 32'h3010);
    cyc("eret_sr", 0, 6'h00, 32'h3010, 0, 0, 0, 12, 0, 0, 0, 0,
        0, 0, 32'h3010, 0, 32'h401);
    cyc("ds_exc", 0, 6'h00, 32'h3024, EXC_OV, 1, 0, 12, 0, 0, 0, 0,
        1, 0, 32'h3010, 0, 32'h401);
    cyc("ds_ca", 0, 6'h00, 32'h4180, 0, 0, 0, 13, 0, 0, 0, 0,
        0, 0, 32'h3020, 0, 32'h8000_0030);
    cyc("ds_eret", 0, 6'h00, 32'h4184, 0, 0, 0, 14, 0, 1, 0, 0,
        0, 1, 32'h3020, 0, 32'h3020);
    cyc("ds_sr", 0, 6'h00, 32'h3020, 0, 0, 0, 12, 0, 0, 0, 0,
        0, 0, 32'h3020, 0, 32'h401);
    cyc("hz_e", 0, 6'h00, 32'h3028, 0, 0, 0, 12, 0, 0, 1, 1,
        0, 0, 32'h3020, 1, 32'h401);
    cyc("hz_m", 0, 6'h00, 32'h302c, 0, 0, 1, 14, 32'h6002, 0, 1, 0,
        0, 0, 32'h3020, 1, 32'h3020);
    cyc("hz_go", 0, 6'h00, 32'h3030, 0, 0, 0, 14, 0, 0, 1, 0,
        0, 0, 32'h6000, 0, 32'h6000);
    cyc("hz_fl", 0, 6'h00, 32'h3034, 0, 0, 0, 12, 0, 1, 1, 1,
        0, 1, 32'h6000, 0, 32'h401);
    cyc("co_mt", 0, 6'h01, 32'h3040, 0, 0, 1, 14, 32'h5000, 0, 1, 0,
        1, 0, 32'h6000, 0, 32'h6000);
    cyc("co_epc", 0, 6'h00, 32'h4180, 0, 0, 0, 14, 0, 0, 0, 0,
        0, 0, 32'h3040, 0, 32'h3040);
    cyc("co_er0", 0, 6'h00, 32'h4184, 0, 0, 0, 12, 0, 1, 0, 0,
        0, 1, 32'h3040, 0, 32'h403);
    cyc("co_ier", 0, 6'h01, 32'h3050, 0, 0, 0, 12, 0, 1, 0, 0,
        1, 0, 32'h3040, 0, 32'h401);
    cyc("co_exl", 0, 6'h00, 32'h4180, 0, 0, 0, 12, 0, 0, 0, 0,
        0, 0, 32'h3050, 0, 32'h403);
    cyc("co_er1", 0, 6'h00, 32'h4184, 0, 0, 0, 13, 0, 1, 0, 0,
        0, 1, 32'h3050, 0, 32'h0);
    cyc("rs_irq", 1, 6'h00, 32'h3060, EXC_ADES, 0, 0, 13, 0, 0, 0, 0,
        1, 0, 32'h3050, 0, 32'h0);
    cyc("rs_sr", 0, 6'h00, 32'h3000, 0, 0, 0, 12, 0, 0, 0, 0,
        0, 0, 32'h0, 0, 32'h0);
    cyc("rs_ca", 0, 6'h00, 32'h3004, 0, 0, 0, 13, 0, 0, 0, 0,
        0, 0, 32'h0, 0, 32'h0);
    cyc("rs_epc", 0, 6'h00, 32'h3008, 0, 0, 0, 14, 0, 0, 0, 0,
        0, 0, 32'h0, 0, 32'h0);
    cyc("prid", 0, 6'h00, 32'h300c, 0, 0, 0, 15, 0, 0, 0, 0,
        0, 0, 32'h0, 0, 32'h2021_0B0A);
    cyc("mt_ca", 0, 6'h00, 32'h3010, 0, 0, 1, 13, 32'hffff_ffff, 0, 0, 0,
        0, 0, 32'h0, 0, 32'h0);
    cyc("ca_ro", 0, 6'h00, 32'h3014, 0, 0, 1, 20, 32'hffff_ffff, 0, 0, 0,
        0, 0, 32'h0, 0, 32'h0);
    cyc("sr_ri", 0, 6'h00, 32'h3018, 0, 0, 0, 13, 0, 0, 0, 0,
        0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
